// File: rtl/sample_rate_sched.sv
`default_nettype none
// ============================================================================
// sample_rate_sched : programmable sample-enable strobe and capture sequencer
// Rev 1.0
// ============================================================================
module sample_rate_sched #(
    parameter int DIV_W = 16,
    parameter int CNT_W = 16
) (
    input  logic             CLKin,
    input  logic             RSTin,
    input  logic             cfg_wr,
    input  logic [DIV_W-1:0] div_in,
    input  logic [CNT_W-1:0] depth_in,
    input  logic             start,
    input  logic             stop,
    output logic             SMPen,
    output logic             CLKout,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] smp_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [DIV_W-1:0] c_div_default = DIV_W'(15);
    localparam logic [DIV_W-1:0] c_div_one     = DIV_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_one     = CNT_W'(1);

    state_t           state_q, state_d;
    logic [DIV_W-1:0] presc_q, presc_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] div_pend_q, div_pend_d;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] depth_q, depth_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             smp_q, smp_d;
    logic             clk_q, clk_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc = cnt_q + c_cnt_one;

    always_ff @(posedge CLKin) begin
        if (RSTin) begin
            state_q    <= S_IDLE;
            presc_q    <= '0;
            div_q      <= c_div_default;
            div_pend_q <= '0;
            pend_q     <= 1'b0;
            depth_q    <= '0;
            cnt_q      <= '0;
            smp_q      <= 1'b0;
            clk_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            div_q      <= div_d;
            div_pend_q <= div_pend_d;
            pend_q     <= pend_d;
            depth_q    <= depth_d;
            cnt_q      <= cnt_d;
            smp_q      <= smp_d;
            clk_q      <= clk_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        div_d      = div_q;
        div_pend_d = div_pend_q;
        pend_d     = pend_q;
        depth_d    = depth_q;
        cnt_d      = cnt_q;
        smp_d      = 1'b0;
        clk_d      = clk_q;
        busy_d     = busy_q;
        done_d     = done_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (cfg_wr) begin
                    div_d   = div_in;
                    depth_d = depth_in;
                end
                // stop on the same edge suppresses the start
                if (start && !stop) begin
                    state_d = S_RUN;
                    presc_d = cfg_wr ? div_in : div_q;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                    clk_d   = 1'b0;
                    pend_d  = 1'b0;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    pend_d  = 1'b0;
                end else begin
                    if (presc_q == '0) begin
                        smp_d = 1'b1;
                        clk_d = ~clk_q;
                        cnt_d = cnt_inc;
                        // a deferred ratio only takes effect at a period boundary
                        if (pend_q) begin
                            presc_d = div_pend_q;
                            div_d   = div_pend_q;
                            pend_d  = 1'b0;
                        end else begin
                            presc_d = div_q;
                        end
                        if ((depth_q != '0) && (cnt_inc == depth_q)) begin
                            state_d = S_DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q - c_div_one;
                    end
                    if (cfg_wr) begin
                        div_pend_d = div_in;
                        pend_d     = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign SMPen   = smp_q;
    assign CLKout  = clk_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign smp_cnt = cnt_q;

endmodule
`default_nettype wire
